// File: rtl/ahb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ahb_pkg
// Description : Shared AHB encodings and FSM state type for the slave
//               interface and its split tracker.
//               Contents:
//                 HTRANS_* - transfer type encodings
//                 HRESP_*  - response encodings
//                 ahb_state_t - slave FSM states
//                 clog2_min1 - ceil(log2(n)), never below 1
// Revision    : 1.0 - initial release
// ============================================================================
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [1:0] HRESP_OKAY  = 2'b00;
  localparam logic [1:0] HRESP_ERROR = 2'b01;
  localparam logic [1:0] HRESP_RETRY = 2'b10;  // reserved, never driven
  localparam logic [1:0] HRESP_SPLIT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_DATA = 2'b01,
    ST_ERR2 = 2'b10,
    ST_SPL2 = 2'b11
  } ahb_state_t;

  // Master IDs need at least one bit even with a single master.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage : ahb_pkg
`default_nettype wire

// File: rtl/ahb_slave_if_pipe_split_tracker.sv
`default_nettype none
// ============================================================================
// Module      : ahb_split_tracker
// Description : Holds the per-master pending SPLIT mask and produces the
//               one-cycle hsplit release pulse.
//               Ports:
//                 hclk, hresetn - clock, async active-low reset
//                 set_en        - record a split for set_id this cycle
//                 set_id        - master ID that was split
//                 resume        - back-end ready; release all pending masters
//                 hsplit        - registered release pulse, one bit per master
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_split_tracker
  import ahb_pkg::*;
#(
  parameter  int NUM_MASTERS = 4,
  localparam int MASTER_W    = clog2_min1(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   set_en,
  input  logic [MASTER_W-1:0]    set_id,
  input  logic                   resume,
  output logic [NUM_MASTERS-1:0] hsplit
);

  logic [NUM_MASTERS-1:0] pending;
  logic [NUM_MASTERS-1:0] set_mask;

  for (genvar i = 0; i < NUM_MASTERS; i++) begin : g_set_dec
    assign set_mask[i] = set_en && (set_id == MASTER_W'(i));
  end

  // A split recorded in the same cycle as resume was not yet pending when
  // the back-end decided to resume, so it survives the release.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pending <= '0;
      hsplit  <= '0;
    end else if (resume) begin
      hsplit  <= pending;
      pending <= set_mask;
    end else begin
      hsplit  <= '0;
      pending <= pending | set_mask;
    end
  end

endmodule : ahb_split_tracker
`default_nettype wire

// File: rtl/ahb_slave_if_pipe.sv
`default_nettype none
// ============================================================================
// Module      : ahb_slave_if_pipe
// Description : Pipelined AHB slave interface. Captures the address phase,
//               runs a req/ack handshake with a generic back-end during the
//               data phase (wait states until ack), generates the two-cycle
//               ERROR and SPLIT responses and tracks split masters.
//               Optional macro AHB_SLV_TIMEOUT_EN adds a back-end watchdog
//               that forces ERROR after TIMEOUT_CYCLES unacked DATA cycles.
//               Ports:
//                 hclk, hresetn          - clock, async active-low reset
//                 hsel, haddr, hwrite,
//                 htrans, hwdata,
//                 hready_in, hmaster     - AHB fabric inputs
//                 hrdata, hready, hresp,
//                 hsplit                 - AHB slave outputs
//                 be_req, be_write,
//                 be_addr, be_wdata      - back-end request side
//                 be_ack, be_rdata,
//                 be_error, be_split,
//                 be_resume              - back-end response side
// Revision    : 1.0 - initial release
// ============================================================================
module ahb_slave_if_pipe
  import ahb_pkg::*;
#(
  parameter  int ADDR_W         = 32,
  parameter  int DATA_W         = 32,
  parameter  int NUM_MASTERS    = 4,
  parameter  int TIMEOUT_CYCLES = 256,
  localparam int MASTER_W       = clog2_min1(NUM_MASTERS)
) (
  input  logic                   hclk,
  input  logic                   hresetn,
  input  logic                   hsel,
  input  logic [ADDR_W-1:0]      haddr,
  input  logic                   hwrite,
  input  logic [1:0]             htrans,
  input  logic [DATA_W-1:0]      hwdata,
  input  logic                   hready_in,
  input  logic [MASTER_W-1:0]    hmaster,
  output logic [DATA_W-1:0]      hrdata,
  output logic                   hready,
  output logic [1:0]             hresp,
  output logic [NUM_MASTERS-1:0] hsplit,
  output logic                   be_req,
  output logic                   be_write,
  output logic [ADDR_W-1:0]      be_addr,
  output logic [DATA_W-1:0]      be_wdata,
  input  logic                   be_ack,
  input  logic [DATA_W-1:0]      be_rdata,
  input  logic                   be_error,
  input  logic                   be_split,
  input  logic                   be_resume
);

  ahb_state_t          state;
  ahb_state_t          next_state;
  logic [MASTER_W-1:0] master_q;
  logic                accept;
  logic                capture;
  logic                split_set;
  logic                timeout;

  assign accept = hsel && hready_in &&
                  ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));

  // Only take a new address phase when this slave is also ending the
  // previous data phase, so a stray hready_in cannot corrupt a stalled
  // transfer's latched address.
  assign capture = accept && hready;

  assign be_wdata = hwdata;

`ifdef AHB_SLV_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] wait_cnt;

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      wait_cnt <= '0;
    end else if ((state == ST_DATA) && !be_ack && !timeout) begin
      wait_cnt <= wait_cnt + TO_W'(1);
    end else begin
      wait_cnt <= '0;
    end
  end

  assign timeout = (state == ST_DATA) && (wait_cnt == TO_W'(TIMEOUT_CYCLES));
`else
  assign timeout = 1'b0;

  // TIMEOUT_CYCLES stays in the parameter list so both builds share one
  // instantiation interface; nothing depends on it here.
  if (TIMEOUT_CYCLES < 1) begin : g_timeout_unused
  end
`endif

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      be_addr  <= '0;
      be_write <= 1'b0;
      master_q <= '0;
    end else if (capture) begin
      be_addr  <= haddr;
      be_write <= hwrite;
      master_q <= hmaster;
    end
  end

  always_comb begin
    next_state = state;
    hready     = 1'b1;
    hresp      = HRESP_OKAY;
    hrdata     = '0;
    be_req     = 1'b0;
    split_set  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (accept) next_state = ST_DATA;
      end

      ST_DATA: begin
        if (timeout) begin
          // Watchdog expiry: behave as a back-end error, drop the request
          // and ignore any late ack.
          hready     = 1'b0;
          hresp      = HRESP_ERROR;
          next_state = ST_ERR2;
        end else begin
          be_req = 1'b1;
          hready = 1'b0;
          if (be_ack) begin
            if (be_error) begin
              hresp      = HRESP_ERROR;
              next_state = ST_ERR2;
            end else if (be_split) begin
              hresp      = HRESP_SPLIT;
              split_set  = 1'b1;
              next_state = ST_SPL2;
            end else begin
              hready     = 1'b1;
              if (!be_write) hrdata = be_rdata;
              next_state = accept ? ST_DATA : ST_IDLE;
            end
          end
        end
      end

      ST_ERR2: begin
        hresp      = HRESP_ERROR;
        next_state = accept ? ST_DATA : ST_IDLE;
      end

      ST_SPL2: begin
        hresp      = HRESP_SPLIT;
        next_state = accept ? ST_DATA : ST_IDLE;
      end

      default: begin
        next_state = ST_IDLE;
      end
    endcase
  end

  ahb_split_tracker #(
    .NUM_MASTERS (NUM_MASTERS)
  ) u_split_tracker (
    .hclk    (hclk),
    .hresetn (hresetn),
    .set_en  (split_set),
    .set_id  (master_q),
    .resume  (be_resume),
    .hsplit  (hsplit)
  );

endmodule : ahb_slave_if_pipe
`default_nettype wire

// File: tb/tb_ahb_slave_if_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_ahb_slave_if_pipe
// Description : Self-checking bench for ahb_slave_if_pipe. Per-cycle
//               expected slave outputs are queued as stimulus is driven and
//               compared by a monitor on the falling clock edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ahb_slave_if_pipe;
  import ahb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NM = 4;
  localparam int MW = 2;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic          hsel;
  logic [AW-1:0] haddr;
  logic          hwrite;
  logic [1:0]    htrans;
  logic [DW-1:0] hwdata;
  logic          hready_in;
  logic [MW-1:0] hmaster;
  logic [DW-1:0] hrdata;
  logic          hready;
  logic [1:0]    hresp;
  logic [NM-1:0] hsplit;
  logic          be_req;
  logic          be_write;
  logic [AW-1:0] be_addr;
  logic [DW-1:0] be_wdata;
  logic          be_ack;
  logic [DW-1:0] be_rdata;
  logic          be_error;
  logic          be_split;
  logic          be_resume;

  always #5 hclk = ~hclk;

  ahb_slave_if_pipe #(
    .ADDR_W         (AW),
    .DATA_W         (DW),
    .NUM_MASTERS    (NM),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .hclk      (hclk),
    .hresetn   (hresetn),
    .hsel      (hsel),
    .haddr     (haddr),
    .hwrite    (hwrite),
    .htrans    (htrans),
    .hwdata    (hwdata),
    .hready_in (hready_in),
    .hmaster   (hmaster),
    .hrdata    (hrdata),
    .hready    (hready),
    .hresp     (hresp),
    .hsplit    (hsplit),
    .be_req    (be_req),
    .be_write  (be_write),
    .be_addr   (be_addr),
    .be_wdata  (be_wdata),
    .be_ack    (be_ack),
    .be_rdata  (be_rdata),
    .be_error  (be_error),
    .be_split  (be_split),
    .be_resume (be_resume)
  );

  typedef struct packed {
    logic          hready;
    logic [1:0]    hresp;
    logic [DW-1:0] hrdata;
    logic          be_req;
  } exp_t;

  exp_t  sb[$];
  string sb_tag[$];
  int    vectors     = 0;
  int    miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Queue this cycle's expected outputs, then advance to just after the
  // next rising edge.
  task automatic step(input string tag, input logic rdy, input logic [1:0] rsp,
                      input logic [DW-1:0] rd, input logic req);
    exp_t e;
    e.hready = rdy;
    e.hresp  = rsp;
    e.hrdata = rd;
    e.be_req = req;
    sb.push_back(e);
    sb_tag.push_back(tag);
    @(posedge hclk);
    #1;
  endtask

  exp_t  mon_e;
  string mon_t;
  always @(negedge hclk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      mon_t = sb_tag.pop_front();
      chk({mon_t, ".hready"}, {31'd0, hready}, {31'd0, mon_e.hready});
      chk({mon_t, ".hresp"},  {30'd0, hresp},  {30'd0, mon_e.hresp});
      chk({mon_t, ".hrdata"}, hrdata,          mon_e.hrdata);
      chk({mon_t, ".be_req"}, {31'd0, be_req}, {31'd0, mon_e.be_req});
    end
  end

  task automatic idle_bus();
    hsel     = 1'b1;
    htrans   = HTRANS_IDLE;
    be_ack   = 1'b0;
    be_error = 1'b0;
    be_split = 1'b0;
    be_resume = 1'b0;
  endtask

  // Address phase, split ack, second SPLIT cycle; leaves the bus idle.
  task automatic split_xfer(input logic [MW-1:0] m, input logic [AW-1:0] a,
                            input logic resume_in_ack);
    htrans  = HTRANS_NONSEQ;
    hmaster = m;
    haddr   = a;
    hwrite  = 1'b0;
    step("spl_ap", 1'b1, HRESP_OKAY, '0, 1'b0);
    htrans    = HTRANS_IDLE;
    be_ack    = 1'b1;
    be_split  = 1'b1;
    be_resume = resume_in_ack;
    step("spl_c1", 1'b0, HRESP_SPLIT, '0, 1'b1);
    chk("spl_hsplit", {28'd0, hsplit}, 32'd0);
    be_ack    = 1'b0;
    be_split  = 1'b0;
    be_resume = 1'b0;
    step("spl_c2", 1'b1, HRESP_SPLIT, '0, 1'b0);
  endtask

  task automatic resume_pulse(input logic [NM-1:0] exp_mask);
    be_resume = 1'b1;
    step("res", 1'b1, HRESP_OKAY, '0, 1'b0);
    be_resume = 1'b0;
    chk("hsplit_pulse", {28'd0, hsplit}, {28'd0, exp_mask});
    step("res1", 1'b1, HRESP_OKAY, '0, 1'b0);
    chk("hsplit_clear", {28'd0, hsplit}, 32'd0);
  endtask

  initial begin
    hresetn   = 1'b0;
    hsel      = 1'b0;
    haddr     = '0;
    hwrite    = 1'b0;
    htrans    = HTRANS_IDLE;
    hwdata    = '0;
    hready_in = 1'b1;
    hmaster   = '0;
    be_ack    = 1'b0;
    be_rdata  = '0;
    be_error  = 1'b0;
    be_split  = 1'b0;
    be_resume = 1'b0;

    @(posedge hclk);
    #1;
    step("rst", 1'b1, HRESP_OKAY, '0, 1'b0);
    chk("rst_hsplit", {28'd0, hsplit}, 32'd0);
    chk("rst_be_addr", be_addr, 32'd0);
    chk("rst_be_write", {31'd0, be_write}, 32'd0);
    hresetn = 1'b1;
    step("rel", 1'b1, HRESP_OKAY, '0, 1'b0);

    // IDLE and BUSY while selected: zero-wait OKAY, no back-end request
    idle_bus();
    for (int i = 0; i < 3; i++) step("idle", 1'b1, HRESP_OKAY, '0, 1'b0);
    htrans = HTRANS_BUSY;
    step("busy", 1'b1, HRESP_OKAY, '0, 1'b0);

    // NONSEQ write, back-end acks on the third data cycle
    htrans = HTRANS_NONSEQ;
    haddr  = 32'h40;
    hwrite = 1'b1;
    step("wr_ap", 1'b1, HRESP_OKAY, '0, 1'b0);
    htrans = HTRANS_IDLE;
    haddr  = 32'hFFFF_0000;
    hwdata = 32'hDEAD_BEEF;
    chk("wr_be_addr", be_addr, 32'h40);
    chk("wr_be_write", {31'd0, be_write}, 32'd1);
    chk("wr_be_wdata", be_wdata, 32'hDEAD_BEEF);
    step("wr_w1", 1'b0, HRESP_OKAY, '0, 1'b1);
    step("wr_w2", 1'b0, HRESP_OKAY, '0, 1'b1);
    chk("wr_wdata_hold", be_wdata, 32'hDEAD_BEEF);
    be_ack   = 1'b1;
    be_rdata = 32'h5555_AAAA;
    step("wr_done", 1'b1, HRESP_OKAY, '0, 1'b1);
    be_ack = 1'b0;
    step("wr_idle", 1'b1, HRESP_OKAY, '0, 1'b0);

    // Back-to-back reads with immediate ack
    htrans = HTRANS_NONSEQ;
    haddr  = 32'h100;
    hwrite = 1'b0;
    step("rd_ap", 1'b1, HRESP_OKAY, '0, 1'b0);
    htrans   = HTRANS_SEQ;
    haddr    = 32'h104;
    be_ack   = 1'b1;
    be_rdata = 32'h11;
    step("rd_d1", 1'b1, HRESP_OKAY, 32'h11, 1'b1);
    chk("rd_be_addr2", be_addr, 32'h104);
    htrans   = HTRANS_IDLE;
    be_rdata = 32'h22;
    step("rd_d2", 1'b1, HRESP_OKAY, 32'h22, 1'b1);
    be_ack = 1'b0;
    step("rd_idle", 1'b1, HRESP_OKAY, '0, 1'b0);

    // Error with split also asserted: error wins, nothing becomes pending
    htrans = HTRANS_NONSEQ;
    haddr  = 32'h200;
    step("er_ap", 1'b1, HRESP_OKAY, '0, 1'b0);
    htrans   = HTRANS_IDLE;
    be_ack   = 1'b1;
    be_error = 1'b1;
    be_split = 1'b1;
    be_rdata = 32'h99;
    step("er_c1", 1'b0, HRESP_ERROR, '0, 1'b1);
    be_ack   = 1'b0;
    be_error = 1'b0;
    be_split = 1'b0;
    step("er_c2", 1'b1, HRESP_ERROR, '0, 1'b0);
    step("er_idle", 1'b1, HRESP_OKAY, '0, 1'b0);

    // Splits from masters 1 and 3, then release
    split_xfer(2'd1, 32'h300, 1'b0);
    split_xfer(2'd3, 32'h304, 1'b0);
    resume_pulse(4'b1010);

    // Split recorded in the resume cycle stays pending for the next release
    split_xfer(2'd2, 32'h308, 1'b1);
    chk("same_cyc_hsplit", {28'd0, hsplit}, 32'd0);
    resume_pulse(4'b0100);

    // Asynchronous reset in the middle of a data phase
    split_xfer(2'd0, 32'h30C, 1'b0);
    htrans = HTRANS_NONSEQ;
    haddr  = 32'h500;
    hwrite = 1'b0;
    step("ar_ap", 1'b1, HRESP_OKAY, '0, 1'b0);
    htrans   = HTRANS_IDLE;
    be_rdata = 32'h1234_5678;
    #1;
    chk("ar_pre_req", {31'd0, be_req}, 32'd1);
    #1;
    hresetn = 1'b0;
    be_ack  = 1'b1;
    #1;
    chk("ar_hready", {31'd0, hready}, 32'd1);
    chk("ar_hresp", {30'd0, hresp}, 32'd0);
    chk("ar_hrdata", hrdata, 32'd0);
    chk("ar_be_req", {31'd0, be_req}, 32'd0);
    chk("ar_be_addr", be_addr, 32'd0);
    @(posedge hclk);
    #1;
    hresetn = 1'b1;
    be_ack  = 1'b0;
    resume_pulse(4'b0000);

`ifdef AHB_SLV_TIMEOUT_EN
    // Watchdog: 8 unacked cycles, then ERROR; a late ack is ignored
    htrans = HTRANS_NONSEQ;
    haddr  = 32'h600;
    step("to_ap", 1'b1, HRESP_OKAY, '0, 1'b0);
    htrans = HTRANS_IDLE;
    for (int i = 0; i < 8; i++) step("to_wait", 1'b0, HRESP_OKAY, '0, 1'b1);
    be_ack   = 1'b1;
    be_rdata = 32'hBAD0_BAD0;
    step("to_c1", 1'b0, HRESP_ERROR, '0, 1'b0);
    step("to_c2", 1'b1, HRESP_ERROR, '0, 1'b0);
    step("to_idle", 1'b1, HRESP_OKAY, '0, 1'b0);
    be_ack = 1'b0;
`else
    // Without the watchdog a silent back-end stalls indefinitely
    htrans = HTRANS_NONSEQ;
    haddr  = 32'h600;
    step("nw_ap", 1'b1, HRESP_OKAY, '0, 1'b0);
    htrans = HTRANS_IDLE;
    for (int i = 0; i < 20; i++) step("nw_wait", 1'b0, HRESP_OKAY, '0, 1'b1);
    be_ack   = 1'b1;
    be_rdata = 32'h600D;
    step("nw_done", 1'b1, HRESP_OKAY, 32'h600D, 1'b1);
    be_ack = 1'b0;
    step("nw_idle", 1'b1, HRESP_OKAY, '0, 1'b0);
`endif

    @(negedge hclk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_ahb_slave_if_pipe
`default_nettype wire

// File: doc/ahb_slave_if_pipe.md
Name: ahb_slave_if_pipe

Overview:
- Parametrised AHB slave interface between the decoder/arbiter bus fabric and a generic slave back-end.
- Captures the address phase and runs a req/ack handshake to the back-end during the data phase, inserting wait states until the back-end acks.
- Generates the two-cycle ERROR and SPLIT responses and tracks split masters per master ID.
- Successor to the fixed 32-bit, registered-passthrough slave interface: adds width/master-count generics and correct pipelining.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_MASTERS, 4, masters tracked for SPLIT; MASTER_W = clog2(NUM_MASTERS), minimum 1
- TIMEOUT_CYCLES, 256, back-end watchdog limit; used only when the optional feature is compiled in

Ports:
- hclk  in  1  bus clock
- hresetn  in  1  asynchronous, active-low reset
- hsel  in  1  select from decoder
- haddr  in  ADDR_W  address
- hwrite  in  1  1 = write, 0 = read
- htrans  in  2  00 IDLE, 01 BUSY, 10 NONSEQ, 11 SEQ
- hwdata  in  DATA_W  write data, valid in the data phase
- hready_in  in  1  bus-level HREADY (muxed)
- hmaster  in  MASTER_W  current address-phase master, from arbiter
- hrdata  out  DATA_W  read data
- hready  out  1  transfer done (low = wait)
- hresp  out  2  00 OKAY, 01 ERROR, 10 RETRY, 11 SPLIT
- hsplit  out  NUM_MASTERS  per-master split-release pulse
- be_req  out  1  back-end request
- be_write  out  1  latched hwrite
- be_addr  out  ADDR_W  latched haddr
- be_wdata  out  DATA_W  equal to hwdata
- be_ack  in  1  back-end completes the access this cycle
- be_rdata  in  DATA_W  valid with be_ack on reads
- be_error  in  1  qualified by be_ack; ERROR response
- be_split  in  1  qualified by be_ack; SPLIT response
- be_resume  in  1  one-cycle pulse: back-end ready to serve split masters

Behaviour:
- Reset is asynchronous, active-low, and may assert mid-transfer. It forces:
  - state to IDLE
  - hready=1, hresp=00, hrdata=0, hsplit=0
  - be_req=0, be_write=0, be_addr=0
  - pending split mask = 0
- Accept condition: hsel && hready_in && htrans[1]. On accept, latch haddr, hwrite and hmaster, and enter DATA.
- IDLE/BUSY with hsel: no state change; hready=1, hresp=OKAY (zero-wait).
- FSM states:
  - IDLE: hready=1, hresp=00. On accept, go to DATA.
  - DATA:
    - be_req=1; hready follows be_ack combinationally; hresp=00.
    - On be_ack without error or split, the transfer completes. hrdata=be_rdata for reads, 0 for writes.
    - On be_ack with no error or split, the next state is DATA if an accept occurs in the same cycle (back-to-back, zero bubble), else IDLE.
    - be_ack && be_error: hready=0, hresp=01; go to ERR2.
    - be_ack && be_split: hready=0, hresp=11; set pending[latched master]; go to SPL2.
    - If be_error and be_split are both high, be_error has priority.
  - ERR2: hready=1, hresp=01. An accept in this cycle is honoured (go to DATA), else go to IDLE.
  - SPL2: hready=1, hresp=11. Same accept rule as ERR2.
- hrdata is 0 outside a completing read.
- Split release:
  - When be_resume is seen, hsplit is registered to the pending mask for exactly one cycle, then pending is cleared.
  - A new split bit set in the same cycle as be_resume stays pending. It is not released in that pulse.
- RETRY (10) is never generated by this block; the encoding is reserved.
- be_wdata passes hwdata through and remains valid throughout wait states.

Optional Feature:
- Macro: AHB_SLV_TIMEOUT_EN.
- With the macro defined:
  - A counter of width clog2(TIMEOUT_CYCLES+1) increments each DATA cycle without be_ack and clears on leaving DATA.
  - When the count reaches TIMEOUT_CYCLES, the block produces the two-cycle ERROR response (as for be_error) and drops be_req.
  - A late be_ack is ignored.
- Without the macro: no counter, and DATA waits indefinitely.

Decomposition:
- Shared package ahb_pkg:
  - HTRANS_IDLE/BUSY/NONSEQ/SEQ
  - HRESP_OKAY/ERROR/RETRY/SPLIT
  - FSM state enum (IDLE, DATA, ERR2, SPL2)
- One sub-module, ahb_split_tracker: holds the pending mask, set/clear logic and the registered hsplit pulse; parameter NUM_MASTERS.

Test Plan:
- Reset release, then an IDLE htrans with hsel=1 -> hready=1, hresp=00, be_req=0 every cycle.
- NONSEQ write haddr=0x40, hwdata=0xDEADBEEF, be_ack after 2 cycles -> be_addr=0x40, be_wdata=0xDEADBEEF, hready low for 2 cycles then high, hresp=00.
- Back-to-back SEQ reads, be_ack immediate, be_rdata=0x11 then 0x22 -> hrdata 0x11 then 0x22 in consecutive cycles, no bubble.
- Read with be_ack && be_error -> cycle 1 hready=0, hresp=01; cycle 2 hready=1, hresp=01; then IDLE.
- Splits from hmaster=1 and hmaster=3, then be_resume -> each split gives the two-cycle 11 response; hsplit=4'b1010 for one cycle, then 0.
- hresetn asserted mid-DATA -> all outputs at reset values immediately (asynchronous), pending mask cleared.
- With AHB_SLV_TIMEOUT_EN and TIMEOUT_CYCLES=8, no be_ack -> ERROR response after 8 wait cycles, and a be_ack arriving afterwards is ignored.
